mem_arb_intf: RTL

- Parametrised successor to the single-requester memory interface.
- Arbitrates NCH load/store requesters onto one single-port SRAM req/resp handshake, using round-robin priority.
- Presents a per-channel done pulse, a shared read-data bus and a timeout error flag.
- Sits between the execution/fetch units and sram_single_port. Data buses to memory are split into separate read and write buses, not tristate.

---
 rtl/mem_arb_intf.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mem_arb_intf.sv
// Round-robin arbiter of NCH load/store requesters onto one single-port SRAM req/resp handshake.
// Latency: request sampled in IDLE -> req next cycle; mem_resp -> done one cycle later (best case 2 cycles).
// Backpressure: a level request is held until its done pulse; a silent memory is abandoned after TMO cycles with err.
module mem_arb_intf #(
    parameter int NCH = 2,
    parameter int DW  = 16,
    parameter int AW  = 14,
    parameter int TMO = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NCH-1:0]      store,
    input  logic [NCH-1:0]      load,
    input  logic [NCH*DW-1:0]   wdata,
    input  logic [NCH*AW-1:0]   addr,
    output logic [NCH-1:0]      done,
    output logic                err,
    output logic [DW-1:0]       rdata,
    output logic                write_req,
    output logic                read_req,
    output logic [AW-1:0]       addrout,
    output logic [DW-1:0]       wdata_out,
    input  logic [DW-1:0]       rdata_in,
    input  logic                mem_resp
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = $clog2(TMO);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_grant;
    logic            r_is_store;
    logic            r_timeout;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rdata;
    logic [CW-1:0]   r_cnt;

    logic [NCH-1:0]   w_pending;
    logic [2*NCH-1:0] w_rot;
    logic             w_found;
    logic [PW:0]      w_sum;
    logic [PW-1:0]    w_sel;
    logic             w_tmo_hit;
    logic             w_start;

    assign w_pending = store | load;
    assign w_tmo_hit = (r_cnt == CW'(TMO - 1));
    assign w_start   = (r_state == S_IDLE) && w_found;

    // Rotate the pending vector so bit 0 is the channel at ptr, take the first set bit, map back modulo NCH.
    always_comb begin
        w_rot   = {w_pending, w_pending} >> r_ptr;
        w_found = 1'b0;
        w_sum   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_ptr} + (PW+1)'(i);
            end
        end
        if (w_sum >= (PW+1)'(NCH)) begin
            w_sum = w_sum - (PW+1)'(NCH);
        end
        w_sel = w_sum[PW-1:0];
    end

    // Next-state logic for the IDLE -> WAIT -> DONE access sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_WAIT;
            S_WAIT:  if (mem_resp || w_tmo_hit) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register; reset forces IDLE so req drops without waiting for a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the granted channel's command; store wins over load on the same channel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grant    <= '0;
            r_is_store <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else if (w_start) begin
            r_grant    <= w_sel;
            r_is_store <= store[w_sel];
            r_addr     <= addr[int'(w_sel)*AW +: AW];
            r_wdata    <= wdata[int'(w_sel)*DW +: DW];
        end
    end

    // Timeout counter: cleared when the access starts, counts WAIT cycles, saturates at TMO-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_start) begin
            r_cnt <= '0;
        end else if (r_state == S_WAIT && !w_tmo_hit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Error flag for the DONE cycle; a response in the last WAIT cycle still counts as success.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timeout <= 1'b0;
        end else if (r_state == S_WAIT) begin
            r_timeout <= !mem_resp && w_tmo_hit;
        end else if (r_state == S_IDLE) begin
            r_timeout <= 1'b0;
        end
    end

    // Read data is only replaced by a successful load; stores and timeouts leave it alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
        end else if (r_state == S_WAIT && mem_resp && !r_is_store) begin
            r_rdata <= rdata_in;
        end
    end

    // Advance the round-robin pointer past the channel just served.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (r_state == S_DONE) begin
            if (r_grant == PW'(NCH - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= r_grant + 1'b1;
            end
        end
    end

    // Done is a one-hot pulse to the granted channel during the DONE cycle.
    always_comb begin
        done = '0;
        if (r_state == S_DONE) begin
            done[r_grant] = 1'b1;
        end
    end

    assign err       = (r_state == S_DONE) && r_timeout;
    assign write_req = (r_state == S_WAIT) && r_is_store;
    assign read_req  = (r_state == S_WAIT) && !r_is_store;
    assign addrout   = r_addr;
    assign wdata_out = r_wdata;
    assign rdata     = r_rdata;

endmodule
